hazard_stall_unit: RTL and testbench

//   Produces the pipeline stall/flush controls that the 5-stage MIPS datapath consumes.

---
 rtl/mips_hazard_pkg.sv | 15 +
 rtl/md_busy_tracker.sv | 54 +++++
 rtl/hazard_stall_unit.sv | 85 ++++++++
 tb/tb_hazard_stall_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mips_hazard_pkg.sv
// Shared types and default timing for the MIPS hazard/stall logic.
package mips_hazard_pkg;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam int DEF_MULT_CYCLES = 4;
    localparam int DEF_DIV_CYCLES  = 32;
    localparam int DEF_CNT_W       = 6;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks the multi-cycle mult/div unit: busy for exactly N cycles after the issue cycle.
module md_busy_tracker
    import mips_hazard_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             md_start_e,
    input  logic             md_is_div_e,
    output logic             md_busy,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;

    // A start seen while BUSY is dropped: md_hold keeps the next md op out of E.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (md_start_e) begin
                        cnt_reg   <= md_is_div_e ? DIV_LOAD : MULT_LOAD;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign md_busy = (state_reg == BUSY);
    assign cnt     = cnt_reg;

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush control for the 5-stage MIPS pipe: load-use and HI/LO hazards.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_COUNT_EN.
module hazard_stall_unit
    import mips_hazard_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic        rs_used_d,
    input  logic        rt_used_d,
    input  logic        md_op_d,
    input  logic        mem_read_e,
    input  logic [4:0]  rd_e,
    input  logic        md_start_e,
    input  logic        md_is_div_e,
    input  logic        ext_stall,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_e,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);

    reg_idx_t         rd_e_idx;
    logic             load_use;
    logic             md_hold;
    logic             hazard;
    logic             stall_any;
    logic [CNT_W-1:0] md_cnt;

    md_busy_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .md_start_e  (md_start_e),
        .md_is_div_e (md_is_div_e),
        .md_busy     (md_busy),
        .cnt         (md_cnt)
    );

    assign rd_e_idx = rd_e;

    // $zero is never a real producer, so a load into r0 must not stall.
    assign load_use = mem_read_e && (rd_e_idx != '0) &&
                      ((rs_used_d && (rs_d == rd_e_idx)) ||
                       (rt_used_d && (rt_d == rd_e_idx)));

    assign md_hold   = md_op_d && md_busy;
    assign hazard    = load_use || md_hold;
    assign stall_any = hazard || ext_stall;

    // Controls are forced low while reset is held so the datapath sees a clean pipe.
    assign stall_f = rst_n && stall_any;
    assign stall_d = rst_n && stall_any;
    assign flush_e = rst_n && hazard && !ext_stall;

    // The counter only rests at zero once the unit has gone idle.
    idle_cnt_zero: assert property (@(posedge clk) disable iff (!rst_n)
                                    !md_busy |-> (md_cnt == '0));

`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] stall_cycles_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_reg <= '0;
        end else if (stall_d && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit (default 4/32-cycle mult/div).
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs_d, rt_d, rd_e;
    logic        rs_used_d, rt_used_d, md_op_d, mem_read_e;
    logic        md_start_e, md_is_div_e, ext_stall;
    logic        stall_f, stall_d, flush_e, md_busy;
    logic [31:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_stall_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .rs_used_d    (rs_used_d),
        .rt_used_d    (rt_used_d),
        .md_op_d      (md_op_d),
        .mem_read_e   (mem_read_e),
        .rd_e         (rd_e),
        .md_start_e   (md_start_e),
        .md_is_div_e  (md_is_div_e),
        .ext_stall    (ext_stall),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_e      (flush_e),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("t=%0t check %s observed=%0h expected=%0h", $time, tag, obs, exp);
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_d = 5'd0; rt_d = 5'd0; rd_e = 5'd0;
        rs_used_d = 1'b0; rt_used_d = 1'b0; md_op_d = 1'b0; mem_read_e = 1'b0;
        md_start_e = 1'b0; md_is_div_e = 1'b0; ext_stall = 1'b0;
    endtask

    task automatic chk_ctl(input string tag, input logic sf, input logic sd, input logic fe);
        chk({tag, "_stall_f"}, {31'd0, stall_f}, {31'd0, sf});
        chk({tag, "_stall_d"}, {31'd0, stall_d}, {31'd0, sd});
        chk({tag, "_flush_e"}, {31'd0, flush_e}, {31'd0, fe});
    endtask

    logic [31:0] exp_count;

    initial begin
        clear_inputs();
        rst_n = 1'b0;

        // Reset: outputs low even with a live load-use pattern on the inputs.
        mem_read_e = 1'b1; rd_e = 5'd8; rs_d = 5'd8; rs_used_d = 1'b1;
        #2;
        chk_ctl("reset", 1'b0, 1'b0, 1'b0);
        chk("reset_md_busy", {31'd0, md_busy}, 32'd0);
        chk("reset_stall_cycles", stall_cycles, 32'd0);
        tick();
        clear_inputs();
        rst_n = 1'b1;
        tick();

        // 1: lw r8 in E, add using r8 in D -> one-cycle stall and bubble.
        mem_read_e = 1'b1; rd_e = 5'd8; rs_d = 5'd8; rs_used_d = 1'b1;
        #1 chk_ctl("lu_rs", 1'b1, 1'b1, 1'b1);
        tick();
        clear_inputs();
        rs_d = 5'd8; rs_used_d = 1'b1;
        #1 chk_ctl("lu_after", 1'b0, 1'b0, 1'b0);

        // 2: rd_e==0, unused rs, mismatch, and rt-side match.
        mem_read_e = 1'b1; rd_e = 5'd0; rs_d = 5'd0; rs_used_d = 1'b1;
        #1 chk_ctl("lu_rd0", 1'b0, 1'b0, 1'b0);
        rd_e = 5'd8; rs_d = 5'd8; rs_used_d = 1'b0;
        #1 chk_ctl("lu_rs_unused", 1'b0, 1'b0, 1'b0);
        rs_used_d = 1'b1; rs_d = 5'd9;
        #1 chk_ctl("lu_mismatch", 1'b0, 1'b0, 1'b0);
        rt_d = 5'd8; rt_used_d = 1'b1;
        #1 chk_ctl("lu_rt", 1'b1, 1'b1, 1'b1);
        mem_read_e = 1'b0;
        #1 chk_ctl("lu_noload", 1'b0, 1'b0, 1'b0);
        tick();
        clear_inputs();

        // 3: mult issue at T -> busy T+1..T+4, mflo stalled until T+4.
        md_start_e = 1'b1; md_is_div_e = 1'b0;
        #1 chk("mul_T_busy", {31'd0, md_busy}, 32'd0);
        tick();
        md_start_e = 1'b0; md_op_d = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk($sformatf("mul_T%0d_busy", k), {31'd0, md_busy}, 32'd1);
            chk_ctl($sformatf("mul_T%0d", k), 1'b1, 1'b1, 1'b1);
            tick();
        end
        #1;
        chk("mul_T5_busy", {31'd0, md_busy}, 32'd0);
        chk_ctl("mul_T5", 1'b0, 1'b0, 1'b0);

        // Load-use and md_hold together: still a single stall/bubble.
        clear_inputs();
        md_start_e = 1'b1;
        tick();
        md_start_e = 1'b0; md_op_d = 1'b1;
        mem_read_e = 1'b1; rd_e = 5'd3; rt_d = 5'd3; rt_used_d = 1'b1;
        #1 chk_ctl("both", 1'b1, 1'b1, 1'b1);
        clear_inputs();
        repeat (5) tick();
        chk("mul2_done", {31'd0, md_busy}, 32'd0);

        // 4: divide issue, busy through cycle 9, async reset mid-cycle 10.
        md_start_e = 1'b1; md_is_div_e = 1'b1;
        tick();
        clear_inputs();
        for (int k = 1; k <= 9; k++) begin
            #1 chk($sformatf("div_T%0d_busy", k), {31'd0, md_busy}, 32'd1);
            tick();
        end
        #2 rst_n = 1'b0;
        #1 chk("div_rst_busy", {31'd0, md_busy}, 32'd0);
        chk("div_rst_count", stall_cycles, 32'd0);
        tick();
        rst_n = 1'b1;
        md_op_d = 1'b1;
        #1 chk_ctl("div_rst_mflo", 1'b0, 1'b0, 1'b0);
        tick();
        #1 chk("div_rst_idle", {31'd0, md_busy}, 32'd0);
        clear_inputs();

        // 5: ext_stall with load-use -> freeze without bubble, held 5 cycles.
        ext_stall = 1'b1; mem_read_e = 1'b1; rd_e = 5'd8; rs_d = 5'd8; rs_used_d = 1'b1;
        #1 chk_ctl("ext_lu", 1'b1, 1'b1, 1'b0);
        repeat (5) tick();
        clear_inputs();
        #1 chk_ctl("ext_after", 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_STALL_COUNT_EN
        exp_count = 32'd5;
`else
        exp_count = 32'd0;
`endif
        chk("stall_cycles", stall_cycles, exp_count);
        ext_stall = 1'b1;
        #1 chk_ctl("ext_only", 1'b1, 1'b1, 1'b0);
        ext_stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #100000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
